// File: rtl/rpn_sequencer.sv
// RPN program sequencer: runs a small stored program on the stack calculator.
// Ports: clk/nrst, prog_we/prog_addr/prog_data (program load), start, status
// (busy/done/error/err_code/result/pc), calc_* control outputs, calc_out/calc_cnt in.
module rpn_sequencer #(
  parameter int PROG_AW  = 6,
  parameter int CALC_MAX = 1023
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               prog_we,
  input  logic [PROG_AW-1:0] prog_addr,
  input  logic [17:0]        prog_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [15:0]        result,
  output logic [PROG_AW-1:0] pc,
  output logic               calc_nrst,
  output logic               calc_step,
  output logic               calc_push,
  output logic [1:0]         calc_op,
  output logic [15:0]        calc_d,
  input  logic [15:0]        calc_out,
  input  logic [9:0]         calc_cnt
);

  typedef enum logic [3:0] {
    IDLE, CLR_SETUP, CLR_STROBE, CLR_HOLD,
    SETUP, STROBE, HOLD, DONE, ERR
  } state_t;

  localparam logic [PROG_AW-1:0] PC_LAST = '1;
  localparam logic [9:0]         CMAX    = 10'(CALC_MAX);

  state_t state, state_n;

  logic [PROG_AW-1:0] pc_n;
  logic               busy_n, done_n, error_n;
  logic [1:0]         code_n;
  logic [15:0]        result_n;

  logic [17:0] imem [0:(1<<PROG_AW)-1];
  logic [17:0] instr;
  logic        is_push, is_alu, is_halt, is_ill;
  logic        cnt_low, cnt_full;

  // Program memory: no reset, writes locked out during a run
  always_ff @(posedge clk) begin
    if (prog_we && !busy)
      imem[prog_addr] <= prog_data;
  end

  assign instr   = imem[pc];
  assign is_push = instr[17:16] == 2'b00;
  assign is_alu  = instr[17:16] == 2'b01;
  assign is_halt = instr[17:16] == 2'b10;
  assign is_ill  = instr[17:16] == 2'b11;
  assign cnt_low  = calc_cnt < 10'd2;
  assign cnt_full = calc_cnt >= CMAX;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      pc       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'd0;
      result   <= 16'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      busy     <= busy_n;
      done     <= done_n;
      error    <= error_n;
      err_code <= code_n;
      result   <= result_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    busy_n    = busy;
    done_n    = done;
    error_n   = error;
    code_n    = err_code;
    result_n  = result;
    calc_nrst = 1'b1;
    calc_step = 1'b0;
    calc_push = 1'b0;
    calc_op   = 2'd0;
    calc_d    = 16'd0;

    // Instruction fields stay on the bus from SETUP through HOLD
    if (state == SETUP || state == STROBE || state == HOLD) begin
      calc_push = is_push;
      calc_d    = is_push ? instr[15:0] : 16'd0;
      calc_op   = is_alu ? instr[1:0] : 2'd0;
    end

    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          pc_n    = '0;
          done_n  = 1'b0;
          error_n = 1'b0;
          busy_n  = 1'b1;
          state_n = CLR_SETUP;
        end
      end
      CLR_SETUP: begin
        calc_nrst = 1'b0;
        state_n   = CLR_STROBE;
      end
      CLR_STROBE: begin
        calc_nrst = 1'b0;
        calc_step = 1'b1;
        state_n   = CLR_HOLD;
      end
      CLR_HOLD: begin
        calc_nrst = 1'b0;
        state_n   = SETUP;
      end
      SETUP: begin
        if (is_ill) begin
          code_n  = 2'd0;
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = ERR;
        end else if (is_alu && instr[1] && cnt_low) begin
          code_n  = 2'd1;
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = ERR;
        end else if (is_push && cnt_full) begin
          code_n  = 2'd2;
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = ERR;
        end else if (is_halt) begin
          result_n = calc_out;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = DONE;
        end else begin
          state_n = STROBE;
        end
      end
      STROBE: begin
        calc_step = 1'b1;
        state_n   = HOLD;
      end
      HOLD: begin
        if (pc == PC_LAST) begin
          code_n  = 2'd3;
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = ERR;
        end else begin
          pc_n    = pc + 1'b1;
          state_n = SETUP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
Program sequencer for the 16-bit stack calculator (push / negate / add / multiply on a 1024-entry RAM stack). It holds a small RPN program in internal instruction memory. On start it clears the calculator, then issues one calculator step per instruction and checks stack depth before each one. It reports the final top-of-stack or an error code. It sits between the host/test logic and the calculator, and is the only driver of the calculator's control inputs.

Parameters:
PROG_AW, 6, instruction memory address width (depth 2**PROG_AW words)
CALC_MAX, 1023, calculator stack-count ceiling (push refused at this count)

Ports:
clk  in  1  system clock, all state on posedge
nrst  in  1  synchronous active-low reset
prog_we  in  1  write strobe for instruction memory; ignored while busy
prog_addr  in  PROG_AW  instruction write address
prog_data  in  18  instruction word
start  in  1  begin execution at pc=0; sampled only when not busy
busy  out  1  high from the cycle after start is accepted until done or error
done  out  1  level; program reached HALT; cleared on next accepted start
error  out  1  level; execution aborted; cleared on next accepted start
err_code  out  2  valid while error: 0 illegal opcode, 1 underflow, 2 overflow, 3 no HALT
result  out  16  calc_out captured at HALT; holds until next HALT
pc  out  PROG_AW  current/aborting instruction address
calc_nrst  out  1  calculator reset-request level
calc_step  out  1  calculator step strobe, one clk cycle wide
calc_push  out  1  calculator push
calc_op  out  2  calculator op
calc_d  out  16  calculator push data
calc_out  in  16  calculator top of stack
calc_cnt  in  10  calculator stack count

Behaviour:
- Instruction format:
  - [17:16]=00: PUSH imm[15:0]
  - [17:16]=01: ALU, op=[1:0] (0 nop, 1 neg, 2 add, 3 mul)
  - [17:16]=10: HALT
  - [17:16]=11: illegal
- Instruction memory: 2**PROG_AW x 18, synchronous write, asynchronous read at pc. Contents are undefined after power-up and are not cleared by nrst.
- Reset values: busy=0, done=0, error=0, err_code=0, result=0, pc=0, calc_nrst=1, calc_step=0, calc_push=0, calc_op=0, calc_d=0, state=IDLE.
- Reset mid-run aborts immediately. The calculator is left as is; the next run clears it.
- States: IDLE, CLR_SETUP, CLR_STROBE, CLR_HOLD, SETUP, STROBE, HOLD, DONE, ERR.
- IDLE / DONE / ERR + start:
  - pc<=0, done<=0, error<=0, busy<=1, go to CLR_SETUP.
  - start while busy is ignored.
- CLR_SETUP, CLR_STROBE, CLR_HOLD:
  - calc_nrst=0, calc_push=0, calc_op=0 throughout.
  - calc_step=1 only in CLR_STROBE.
  - Then go to SETUP.
- SETUP: decode imem[pc], drive calc_push/op/d (push: push=1, d=imm; ALU: push=0, op), calc_nrst=1, calc_step=0. Checks, in priority order:
  1. Illegal opcode -> ERR, code 0.
  2. ALU add/mul with calc_cnt<2 -> ERR, code 1.
  3. PUSH with calc_cnt>=CALC_MAX -> ERR, code 2.
  4. HALT -> result<=calc_out, done<=1, busy<=0, go to DONE; no strobe.
  5. Otherwise -> STROBE.
  - On error no calc_step is issued.
- STROBE: calc_step=1 for exactly one cycle; push/op/d held.
- HOLD: calc_step=0, push/op/d held.
  - If pc==2**PROG_AW-1: ERR, code 3; pc stays.
  - Else pc<=pc+1, go to SETUP.
- ERR: error<=1, busy<=0; pc holds the failing address.
- calc_push/op/d are stable from SETUP through HOLD, so they are stable one cycle before and one cycle after each step strobe.
- Latency: 3 cycles for the clear, 3 cycles per non-HALT instruction, 1 cycle for HALT.
  - done rises 3+3N+1 rising edges after the edge that samples start, where N is the number of non-HALT instructions.
- NEG and NOP with calc_cnt 0 are allowed and are strobed.
- calc_cnt is sampled in SETUP only.
- prog_we is ignored while busy. It is permitted in IDLE, DONE and ERR.

Test Plan:
- Program PUSH 3, PUSH 4, ALU add, PUSH 5, ALU mul, HALT; start -> 6 calc_step pulses (1 clear + 5), done after 19 edges, result=35, busy=0, pc=5.
- Program PUSH 1, ALU neg, HALT -> result=0xFFFF, done=1, error=0.
- Program PUSH 7, ALU add -> error=1, err_code=1, pc=1, exactly 2 calc_step pulses, done=0.
- Bench calculator model forces calc_cnt=1023; program PUSH 9 -> error=1, err_code=2, pc=0, no step for the PUSH. Separately, a word with [17:16]=11 at pc=0 -> err_code=0.
- All 64 words ALU nop (no HALT) -> error=1, err_code=3, pc=63, 65 calc_step pulses.
- start pulsed while busy, and prog_we while busy -> both ignored, result unchanged. nrst low mid-run -> next edge gives busy=0, calc_step=0, calc_nrst=1; rerun gives the correct result.
